// File: rtl/sensor_fx_pkg.sv
// ============================================================================
// Module : sensor_fx_pkg
// Brief  : Register offsets, bit indices and FSM states for sensor_fx_slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sensor_fx_pkg;

  localparam logic [15:0] REG_ID          = 16'h0000;
  localparam logic [15:0] REG_CTRL        = 16'h0001;
  localparam logic [15:0] REG_STATUS      = 16'h0002;
  localparam logic [15:0] REG_AUTO_PERIOD = 16'h0003;
  localparam logic [15:0] REG_DATA_L      = 16'h0004;
  localparam logic [15:0] REG_DATA_H      = 16'h0005;
  localparam logic [15:0] REG_CNT_OK      = 16'h0006;
  localparam logic [15:0] REG_CNT_ERR     = 16'h0007;

  localparam int CTRL_FIRE = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_CLR  = 7;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_OVR  = 3;
  localparam int ST_MISS = 4;

  localparam logic [7:0] AUTO_PERIOD_RST = 8'd100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sensor_fx_slave_tick_div_ms.sv
// ============================================================================
// Module : tick_div_ms
// Brief  : Divides the 1 us tick into ms and pulses hit every 'period' ms.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_div_ms #(
  parameter int US_PER_MS = 1000,
  parameter int PW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pluse_us,
  input  logic [PW-1:0] period,
  output logic          hit
);

  localparam int UW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

  logic [UW-1:0] r_us_cnt;
  logic [PW-1:0] r_ms_cnt;
  logic          w_ms_tick;
  logic [PW-1:0] w_period_eff;

  assign w_ms_tick    = en & pluse_us & (r_us_cnt == UW'(US_PER_MS - 1));
  assign w_period_eff = (period == '0) ? PW'(1) : period;
  // >= so that lowering the period below the running count still fires promptly
  assign hit          = w_ms_tick & (r_ms_cnt >= (w_period_eff - PW'(1)));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_us_cnt <= '0;
      r_ms_cnt <= '0;
    end else begin
      if (pluse_us) begin
        r_us_cnt <= w_ms_tick ? '0 : r_us_cnt + UW'(1);
      end
      if (w_ms_tick) begin
        r_ms_cnt <= hit ? '0 : r_ms_cnt + PW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sensor_fx_slave.sv
// ============================================================================
// Module : sensor_fx_slave
// Brief  : fx_bus register slave sequencing sensor_core measurements.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sensor_fx_slave
  import sensor_fx_pkg::*;
#(
  parameter logic [7:0] ID_VAL     = 8'h53,
  parameter int         TIMEOUT_MS = 60,
  parameter int         US_PER_MS  = 1000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic [5:0]  dev_id,
  input  logic        fx_wr,
  input  logic [21:0] fx_waddr,
  input  logic [7:0]  fx_data,
  input  logic        fx_rd,
  input  logic [21:0] fx_raddr,
  output logic [7:0]  fx_q,
  input  logic        key_vld,
  output logic        fire_measure,
  input  logic        done_measure,
  input  logic        err_measure,
  input  logic [15:0] data_measure
);

  state_t      r_state, w_next;
  logic        r_auto_en;
  logic [7:0]  r_auto_period;
  logic [15:0] r_data;
  logic [7:0]  r_shadow;
  logic        r_done, r_err, r_ovr, r_miss;
  logic [7:0]  r_cnt_ok, r_cnt_err;
  logic [7:0]  r_q;

  logic        w_wsel, w_rsel;
  logic [15:0] w_woff, w_roff;
  logic        w_ctrl_wr, w_sw_fire, w_clr;
  logic        w_auto_tick, w_timeout, w_req;
  logic        w_done_ev, w_err_ev, w_miss_ev;
  logic        w_status_rd, w_datal_rd, w_datah_rd;
  logic [7:0]  w_status, w_rdata;

  assign w_wsel    = fx_wr & (fx_waddr[21:16] == dev_id);
  assign w_rsel    = fx_rd & (fx_raddr[21:16] == dev_id);
  assign w_woff    = fx_waddr[15:0];
  assign w_roff    = fx_raddr[15:0];

  assign w_ctrl_wr = w_wsel & (w_woff == REG_CTRL);
  assign w_sw_fire = w_ctrl_wr & fx_data[CTRL_FIRE];
  assign w_clr     = w_ctrl_wr & fx_data[CTRL_CLR];

  assign w_req     = key_vld | w_sw_fire | w_auto_tick;
  assign w_miss_ev = w_req & (r_state != S_IDLE);
  // done takes precedence when both responses land together
  assign w_done_ev = (r_state == S_WAIT) & done_measure;
  assign w_err_ev  = (r_state == S_WAIT) & ~done_measure & (err_measure | w_timeout);

  assign w_status_rd = w_rsel & (w_roff == REG_STATUS);
  assign w_datal_rd  = w_rsel & (w_roff == REG_DATA_L);
  assign w_datah_rd  = w_rsel & (w_roff == REG_DATA_H);

  tick_div_ms #(.US_PER_MS(US_PER_MS), .PW(8)) u_auto_tmr (
    .clk      (clk_sys),
    .rst      (rst),
    .en       (r_auto_en),
    .pluse_us (pluse_us),
    .period   (r_auto_period),
    .hit      (w_auto_tick)
  );

  tick_div_ms #(.US_PER_MS(US_PER_MS), .PW(8)) u_timeout_tmr (
    .clk      (clk_sys),
    .rst      (rst),
    .en       (r_state == S_WAIT),
    .pluse_us (pluse_us),
    .period   (8'(TIMEOUT_MS)),
    .hit      (w_timeout)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    fire_measure = 1'b0;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_FIRE;
      S_FIRE: begin
        fire_measure = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: if (done_measure | err_measure | w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result capture and statistics; set events are applied after read-clears
  always_ff @(posedge clk_sys) begin
    if (rst || w_clr) begin
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_miss    <= 1'b0;
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else begin
      if (w_status_rd) begin
        r_err  <= 1'b0;
        r_ovr  <= 1'b0;
        r_miss <= 1'b0;
      end
      if (w_datah_rd) r_done <= 1'b0;
      if (w_done_ev) begin
        r_data <= data_measure;
        r_done <= 1'b1;
        if (r_done) r_ovr <= 1'b1;
        if (r_cnt_ok != 8'hFF) r_cnt_ok <= r_cnt_ok + 8'd1;
      end
      if (w_err_ev) begin
        r_err <= 1'b1;
        if (r_cnt_err != 8'hFF) r_cnt_err <= r_cnt_err + 8'd1;
      end
      if (w_miss_ev) r_miss <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_auto_en     <= 1'b0;
      r_auto_period <= AUTO_PERIOD_RST;
      r_shadow      <= '0;
      r_q           <= '0;
    end else begin
      if (w_ctrl_wr) r_auto_en <= fx_data[CTRL_AUTO];
      if (w_wsel && (w_woff == REG_AUTO_PERIOD)) r_auto_period <= fx_data;
      if (w_datal_rd) r_shadow <= r_data[15:8];
      if (fx_rd) r_q <= w_rsel ? w_rdata : 8'h00;
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[ST_BUSY] = (r_state != S_IDLE);
    w_status[ST_DONE] = r_done;
    w_status[ST_ERR]  = r_err;
    w_status[ST_OVR]  = r_ovr;
    w_status[ST_MISS] = r_miss;
  end

  always_comb begin
    w_rdata = 8'h00;
    case (w_roff)
      REG_ID:          w_rdata = ID_VAL;
      REG_CTRL:        w_rdata = {6'b0, r_auto_en, 1'b0};
      REG_STATUS:      w_rdata = w_status;
      REG_AUTO_PERIOD: w_rdata = r_auto_period;
      REG_DATA_L:      w_rdata = r_data[7:0];
      REG_DATA_H:      w_rdata = r_shadow;
      REG_CNT_OK:      w_rdata = r_cnt_ok;
      REG_CNT_ERR:     w_rdata = r_cnt_err;
      default:         w_rdata = 8'h00;
    endcase
  end

  assign fx_q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_fx_slave.sv
// ============================================================================
// Module : tb_sensor_fx_slave
// Brief  : Self-checking bench for sensor_fx_slave with a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sensor_fx_slave;

  localparam int         US  = 20;
  localparam int         TMO = 60;
  localparam logic [5:0] DEV = 6'h2A;

  logic        clk_sys = 1'b0;
  logic        rst, pluse_us, fx_wr, fx_rd, key_vld, done_measure, err_measure;
  logic [5:0]  dev_id;
  logic [21:0] fx_waddr, fx_raddr;
  logic [7:0]  fx_data;
  logic [15:0] data_measure;
  logic [7:0]  fx_q;
  logic        fire_measure;

  int n_cmp = 0;
  int n_bad = 0;
  int pluse_mode = 1;
  bit chk_on = 1'b0;

  sensor_fx_slave #(.ID_VAL(8'h53), .TIMEOUT_MS(TMO), .US_PER_MS(US)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pluse_us     (pluse_us),
    .dev_id       (dev_id),
    .fx_wr        (fx_wr),
    .fx_waddr     (fx_waddr),
    .fx_data      (fx_data),
    .fx_rd        (fx_rd),
    .fx_raddr     (fx_raddr),
    .fx_q         (fx_q),
    .key_vld      (key_vld),
    .fire_measure (fire_measure),
    .done_measure (done_measure),
    .err_measure  (err_measure),
    .data_measure (data_measure)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;            // 0 idle, 1 firing, 2 awaiting result
  bit          m_auto_en;
  int          m_period;
  logic [15:0] m_data;
  logic [7:0]  m_shadow, m_q;
  bit          m_done, m_err, m_ovr, m_miss;
  int          m_ok, m_errc, m_auto_us, m_wait_us;

  function automatic logic [7:0] reg_val(input int off);
    case (off)
      0: return 8'h53;
      1: return {6'b0, m_auto_en, 1'b0};
      2: return {3'b0, m_miss, m_ovr, m_err, m_done, (m_phase != 0)};
      3: return m_period[7:0];
      4: return m_data[7:0];
      5: return m_shadow;
      6: return m_ok[7:0];
      7: return m_errc[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit wsel, rsel, ctrl_wr, sw_fire, clr, auto_tick, timeout, req, done_ev, err_ev, old_done;
    int woff, roff, pe;
    if (rst) begin
      m_phase = 0; m_auto_en = 0; m_period = 100; m_data = 0; m_shadow = 0; m_q = 0;
      m_done = 0; m_err = 0; m_ovr = 0; m_miss = 0; m_ok = 0; m_errc = 0;
      m_auto_us = 0; m_wait_us = 0;
      return;
    end
    wsel    = fx_wr && (fx_waddr[21:16] == dev_id);
    rsel    = fx_rd && (fx_raddr[21:16] == dev_id);
    woff    = int'(fx_waddr[15:0]);
    roff    = int'(fx_raddr[15:0]);
    ctrl_wr = wsel && woff == 1;
    sw_fire = ctrl_wr && fx_data[0];
    clr     = ctrl_wr && fx_data[7];

    auto_tick = 0;
    if (!m_auto_en) m_auto_us = 0;
    else if (pluse_us) begin
      m_auto_us++;
      pe = (m_period == 0) ? 1 : m_period;
      if ((m_auto_us % US) == 0 && m_auto_us >= pe * US) begin
        auto_tick = 1;
        m_auto_us = 0;
      end
    end

    timeout = 0;
    if (m_phase == 2 && pluse_us) begin
      m_wait_us++;
      if (m_wait_us == TMO * US) timeout = 1;
    end

    req     = key_vld || sw_fire || auto_tick;
    done_ev = m_phase == 2 && done_measure;
    err_ev  = m_phase == 2 && !done_measure && (err_measure || timeout);

    if (fx_rd) m_q = rsel ? reg_val(roff) : 8'h00;
    if (rsel && roff == 4) m_shadow = m_data[15:8];

    old_done = m_done;
    if (clr) begin
      m_data = 0; m_done = 0; m_err = 0; m_ovr = 0; m_miss = 0; m_ok = 0; m_errc = 0;
    end else begin
      if (rsel && roff == 2) begin m_err = 0; m_ovr = 0; m_miss = 0; end
      if (rsel && roff == 5) m_done = 0;
      if (done_ev) begin
        if (old_done) m_ovr = 1;
        m_done = 1;
        m_data = data_measure;
        if (m_ok < 255) m_ok++;
      end
      if (err_ev) begin
        m_err = 1;
        if (m_errc < 255) m_errc++;
      end
      if (req && m_phase != 0) m_miss = 1;
    end
    if (ctrl_wr) m_auto_en = fx_data[1];
    if (wsel && woff == 3) m_period = int'(fx_data);

    case (m_phase)
      0: if (req) m_phase = 1;
      1: begin m_phase = 2; m_wait_us = 0; end
      default: if (done_ev || err_ev) m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
  end

  always @(negedge clk_sys) begin
    if (chk_on) begin
      chk("fire_measure", {15'b0, fire_measure}, {15'b0, m_phase == 1});
      chk("fx_q", {8'b0, fx_q}, {8'b0, m_q});
    end
  end

  initial begin
    pluse_us = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      case (pluse_mode)
        0:       pluse_us = 1'b0;
        1:       pluse_us = ($urandom_range(0, 1) == 1);
        default: pluse_us = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
    fx_wr = 0; fx_rd = 0; key_vld = 0; done_measure = 0; err_measure = 0;
  endtask

  task automatic rd(input int off, input logic [5:0] dv, output logic [7:0] v);
    fx_rd = 1; fx_raddr = {dv, 16'(off)};
    step();
    v = fx_q;
  endtask

  task automatic wr(input int off, input logic [5:0] dv, input logic [7:0] d);
    fx_wr = 1; fx_waddr = {dv, 16'(off)}; fx_data = d;
    step();
  endtask

  function automatic logic [5:0] pick_dev();
    return ($urandom_range(0, 4) == 0) ? 6'($urandom) : DEV;
  endfunction

  initial begin
    logic [7:0] v;
    int nf, last;
    rst = 1; fx_wr = 0; fx_rd = 0; key_vld = 0; done_measure = 0; err_measure = 0;
    dev_id = DEV; fx_waddr = '0; fx_raddr = '0; fx_data = '0; data_measure = '0;
    step();
    chk_on = 1'b1;
    repeat (2) step();
    rst = 0;
    chk("reset fx_q", {8'b0, fx_q}, 16'h0);
    chk("reset fire", {15'b0, fire_measure}, 16'h0);

    // 1: ID and AUTO_PERIOD reset value
    rd(0, DEV, v); chk("ID", {8'b0, v}, 16'h53);
    rd(3, DEV, v); chk("AUTO_PERIOD rst", {8'b0, v}, 16'h64);

    // 2: key trigger, result capture
    key_vld = 1; step();
    chk("key fire", {15'b0, fire_measure}, 16'h1);
    step();
    chk("fire one cycle", {15'b0, fire_measure}, 16'h0);
    repeat (3) step();
    done_measure = 1; data_measure = 16'h1234; step();
    step();
    rd(2, DEV, v); chk("STATUS done", {8'b0, v}, 16'h02);
    rd(4, DEV, v); chk("DATA_L", {8'b0, v}, 16'h34);
    rd(5, DEV, v); chk("DATA_H", {8'b0, v}, 16'h12);
    rd(2, DEV, v); chk("STATUS after DATA_H", {8'b0, v}, 16'h00);
    rd(6, DEV, v); chk("CNT_OK", {8'b0, v}, 16'h01);

    // 3: software fire while busy -> miss
    key_vld = 1; step(); step();
    wr(1, DEV, 8'h01);
    rd(2, DEV, v); chk("STATUS miss", {8'b0, v}, 16'h11);
    rd(2, DEV, v); chk("STATUS miss cleared", {8'b0, v}, 16'h01);
    done_measure = 1; data_measure = 16'hBEEF; step();
    rd(4, DEV, v);
    rd(5, DEV, v); chk("DATA_H 2nd", {8'b0, v}, 16'hBE);

    // 4: timeout, then simultaneous done+err
    pluse_mode = 2;
    key_vld = 1; step();
    repeat (TMO * US - 1) step();
    rd(2, DEV, v); chk("STATUS before timeout", {8'b0, v}, 16'h01);
    step();
    rd(2, DEV, v); chk("STATUS timeout err", {8'b0, v}, 16'h04);
    rd(7, DEV, v); chk("CNT_ERR timeout", {8'b0, v}, 16'h01);
    key_vld = 1; step();
    repeat (3) step();
    done_measure = 1; err_measure = 1; data_measure = 16'h0A0B; step();
    step();
    rd(6, DEV, v); chk("CNT_OK done+err", {8'b0, v}, 16'h03);
    rd(7, DEV, v); chk("CNT_ERR done+err", {8'b0, v}, 16'h01);
    rd(2, DEV, v); chk("STATUS done+err", {8'b0, v}, 16'h02);

    // 5: periodic fires every AUTO_PERIOD ms
    wr(3, DEV, 8'd2);
    wr(1, DEV, 8'h02);
    nf = 0; last = -1;
    for (int i = 0; i < 8 * US + 20 && nf < 3; i++) begin
      step();
      if (fire_measure) begin
        if (last >= 0) chk("auto interval", 16'(i - last), 16'(2 * US));
        last = i;
        nf++;
        step(); step();
        done_measure = 1; data_measure = 16'($urandom);
        i += 3;
        step();
      end
    end
    chk("auto fire count", 16'(nf), 16'd3);
    wr(1, DEV, 8'h00);
    nf = 0;
    for (int i = 0; i < 6 * US; i++) begin
      step();
      if (fire_measure) nf++;
    end
    chk("no fire after auto off", 16'(nf), 16'd0);
    rd(0, DEV ^ 6'h01, v); chk("foreign read", {8'b0, v}, 16'h00);
    wr(3, DEV ^ 6'h01, 8'h77);
    rd(3, DEV, v); chk("foreign write ignored", {8'b0, v}, 16'h02);
    rd(9, DEV, v); chk("unmapped read", {8'b0, v}, 16'h00);

    // 6: reset while waiting
    key_vld = 1; step(); step();
    rst = 1; step(); rst = 0;
    chk("fx_q after rst", {8'b0, fx_q}, 16'h00);
    done_measure = 1; data_measure = 16'h5555; step();
    rd(2, DEV, v); chk("STATUS after rst", {8'b0, v}, 16'h00);
    rd(6, DEV, v); chk("CNT_OK after rst", {8'b0, v}, 16'h00);

    // randomized traffic checked by the model every cycle
    pluse_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      key_vld = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) begin
        fx_rd = 1; fx_raddr = {pick_dev(), 16'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 29) == 0) begin
        fx_wr = 1; fx_waddr = {pick_dev(), 16'($urandom_range(0, 9))};
        fx_data = (fx_waddr[15:0] == 16'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      done_measure = ($urandom_range(0, 19) == 0);
      err_measure  = ($urandom_range(0, 39) == 0);
      data_measure = 16'($urandom);
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
